// File: rtl/mic_ben_burst_dec.sv
// Burst byte-enable decoder: turns a size/offset request into one strobe/offset beat per handshake.
// Optional illegal-encoding flag on o_err is built only when MIC_BEN_ERR_EN is defined.
module mic_ben_burst_dec #(
  parameter int unsigned LOG2_BYTES = 3,
  parameter int unsigned SIZE_W     = 2,
  parameter int unsigned LEN_W      = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_valid,
  output logic                             i_ready,
  input  logic [SIZE_W+LOG2_BYTES-1:0]     i_byte_enables,
  input  logic [LEN_W-1:0]                 i_len,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic [(1<<LOG2_BYTES)-1:0]       o_byte_strobes,
  output logic [LOG2_BYTES-1:0]            o_addr_offset,
  output logic                             o_word_inc,
  output logic                             o_last,
  output logic                             o_err
);

  localparam int unsigned BYTES = 1 << LOG2_BYTES;
  localparam int unsigned BE_W  = SIZE_W + LOG2_BYTES;
  localparam int unsigned W_W   = LOG2_BYTES + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state, state_nxt;
  logic                   accept;
  logic [SIZE_W-1:0]      size_s;
  logic [SIZE_W-1:0]      se;
  logic [LOG2_BYTES-1:0]  off_in;
  logic [LOG2_BYTES-1:0]  align_in;
  logic [W_W-1:0]         w_in;
  logic [BYTES-1:0]       strb_in;
  logic                   err_in;

  logic [W_W-1:0]         w_q, w_nxt;
  logic [LEN_W-1:0]       rem_q, rem_nxt;
  logic [W_W-1:0]         sum;
  logic [BYTES-1:0]       strb_nxt;
  logic [LOG2_BYTES-1:0]  off_nxt;
  logic                   inc_nxt;
  logic                   last_nxt;
  logic                   err_nxt;

  // Request decode: clamp the size to the bus width, align the offset down to the beat width.
  assign size_s   = i_byte_enables[BE_W-1 -: SIZE_W];
  assign off_in   = i_byte_enables[LOG2_BYTES-1:0];
  assign se       = (size_s >= SIZE_W'(LOG2_BYTES)) ? SIZE_W'(LOG2_BYTES) : size_s;
  assign w_in     = W_W'(1) << se;
  assign align_in = off_in & ~LOG2_BYTES'(w_in - W_W'(1));
  assign strb_in  = ~({BYTES{1'b1}} << w_in) << align_in;

`ifdef MIC_BEN_ERR_EN
  assign err_in = (size_s != se) || ((off_in & LOG2_BYTES'(w_in - W_W'(1))) != '0);
`else
  assign err_in = 1'b0;
`endif

  assign o_valid = (state == BURST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BURST;
      BURST:   if (o_ready && o_last && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and next beat: load on accept, otherwise step by one beat width on a non-final handshake.
  always_comb begin
    i_ready  = !reset && (!o_valid || (o_ready && o_last));
    accept   = i_valid && i_ready;
    sum      = {1'b0, o_addr_offset} + w_q;
    w_nxt    = w_q;
    rem_nxt  = rem_q;
    strb_nxt = o_byte_strobes;
    off_nxt  = o_addr_offset;
    inc_nxt  = o_word_inc;
    last_nxt = o_last;
    err_nxt  = o_err;
    if (accept) begin
      w_nxt    = w_in;
      rem_nxt  = i_len;
      strb_nxt = strb_in;
      off_nxt  = align_in;
      inc_nxt  = 1'b0;
      last_nxt = (i_len == '0);
      err_nxt  = err_in;
    end else if (o_valid && o_ready && !o_last) begin
      rem_nxt  = rem_q - LEN_W'(1);
      off_nxt  = sum[LOG2_BYTES-1:0];
      inc_nxt  = sum[LOG2_BYTES];
      strb_nxt = ~({BYTES{1'b1}} << w_q) << sum[LOG2_BYTES-1:0];
      last_nxt = (rem_q == LEN_W'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q            <= '0;
      rem_q          <= '0;
      o_byte_strobes <= '0;
      o_addr_offset  <= '0;
      o_word_inc     <= 1'b0;
      o_last         <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      w_q            <= w_nxt;
      rem_q          <= rem_nxt;
      o_byte_strobes <= strb_nxt;
      o_addr_offset  <= off_nxt;
      o_word_inc     <= inc_nxt;
      o_last         <= last_nxt;
      o_err          <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mic_ben_burst_dec.sv
// Self-checking bench for mic_ben_burst_dec: directed table, corner sequences, randomized run vs a beat-list model.
module tb_mic_ben_burst_dec;

  localparam int unsigned LB    = 3;
  localparam int unsigned SW    = 2;
  localparam int unsigned LW    = 8;
  localparam int unsigned BYTES = 8;
`ifdef MIC_BEN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                clk;
  logic                reset;
  logic                i_valid;
  logic                i_ready;
  logic [SW+LB-1:0]    i_byte_enables;
  logic [LW-1:0]       i_len;
  logic                o_valid;
  logic                o_ready;
  logic [BYTES-1:0]    o_byte_strobes;
  logic [LB-1:0]       o_addr_offset;
  logic                o_word_inc;
  logic                o_last;
  logic                o_err;

  mic_ben_burst_dec #(.LOG2_BYTES(LB), .SIZE_W(SW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_byte_enables(i_byte_enables), .i_len(i_len),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_byte_strobes(o_byte_strobes), .o_addr_offset(o_addr_offset),
    .o_word_inc(o_word_inc), .o_last(o_last), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] strb;
    logic [2:0] off;
    logic       inc;
    logic       last;
    logic       err;
  } beat_t;

  typedef struct packed {
    logic [4:0]  be;
    logic [7:0]  len;
    logic [31:0] strb;
    logic [11:0] off;
    logic [3:0]  inc;
    logic        err;
  } vec_t;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t q[$];
  vec_t  tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Reference: beat k covers bytes starting at aligned_offset + k*width in a flat byte address space.
  function automatic void push_req(input logic [4:0] be, input logic [7:0] len);
    int s, off, se, w, a;
    logic e;
    s   = int'(be[4:3]);
    off = int'(be[2:0]);
    se  = (s > LB) ? LB : s;
    w   = 1 << se;
    a   = (off / w) * w;
    e   = ERR_EN && ((s > LB) || (off % w != 0));
    for (int k = 0; k <= int'(len); k++) begin
      int    addr;
      beat_t b;
      addr   = a + k * w;
      b.strb = 8'(((1 << w) - 1) << (addr % BYTES));
      b.off  = 3'(addr % BYTES);
      b.inc  = (k > 0) && ((addr / BYTES) != ((addr - w) / BYTES));
      b.last = (k == int'(len));
      b.err  = e;
      q.push_back(b);
    end
  endfunction

  task automatic run_vec(input int idx);
    vec_t v;
    v = tbl[idx];
    step();
    i_valid = 1'b1; i_byte_enables = v.be; i_len = v.len; o_ready = 1'b1;
    smp();
    chk("idle_i_ready", i_ready, 1);
    step();
    i_valid = 1'b0;
    for (int k = 0; k <= int'(v.len); k++) begin
      smp();
      chk("tbl_valid", o_valid, 1);
      chk("tbl_strobes", o_byte_strobes, v.strb[8*k +: 8]);
      chk("tbl_offset", o_addr_offset, v.off[3*k +: 3]);
      chk("tbl_word_inc", o_word_inc, v.inc[k]);
      chk("tbl_last", o_last, (k == int'(v.len)));
      chk("tbl_err", o_err, ERR_EN ? v.err : 1'b0);
      step();
    end
    smp();
    chk("tbl_end_idle", o_valid, 0);
  endtask

  initial begin
    logic have;
    int   guard;
    logic exp_ready;

    tbl[0] = '{5'b00_101, 8'd0, 32'h0000_0020, 12'o0005, 4'b0000, 1'b0};
    tbl[1] = '{5'b01_010, 8'd3, 32'h03C0_300C, 12'o0642, 4'b1000, 1'b0};
    tbl[2] = '{5'b11_000, 8'd2, 32'h00FF_FFFF, 12'o0000, 4'b0110, 1'b0};
    tbl[3] = '{5'b10_010, 8'd0, 32'h0000_000F, 12'o0000, 4'b0000, 1'b1};
    tbl[4] = '{5'b11_101, 8'd1, 32'h0000_FFFF, 12'o0000, 4'b0010, 1'b1};
    tbl[5] = '{5'b10_110, 8'd2, 32'h00F0_0FF0, 12'o0404, 4'b0010, 1'b1};
    tbl[6] = '{5'b00_111, 8'd1, 32'h0000_0180, 12'o0007, 4'b0010, 1'b0};

    reset = 1'b1; i_valid = 1'b0; i_byte_enables = '0; i_len = '0; o_ready = 1'b0;
    #3;
    chk("rst_i_ready", i_ready, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_outputs", {o_byte_strobes, o_addr_offset, o_word_inc, o_last, o_err}, 0);
    smp(); smp();
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Backpressure: stall on beat 2 for three cycles with a competing request pending.
    step();
    i_valid = 1'b1; i_byte_enables = 5'b01_010; i_len = 8'd3; o_ready = 1'b1;
    smp(); step();
    i_valid = 1'b0;
    smp();
    chk("bp_beat1", o_byte_strobes, 8'h0C);
    step();
    o_ready = 1'b0; i_valid = 1'b1; i_byte_enables = 5'b00_000; i_len = 8'd0;
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("bp_stall_valid", o_valid, 1);
      chk("bp_stall_hold", {o_byte_strobes, o_addr_offset, o_word_inc, o_last}, {8'h30, 3'd4, 1'b0, 1'b0});
      chk("bp_stall_i_ready", i_ready, 0);
      step();
    end
    o_ready = 1'b1; i_valid = 1'b0;
    smp(); chk("bp_beat2", o_byte_strobes, 8'h30); step();
    smp(); chk("bp_beat3", o_byte_strobes, 8'hC0); step();
    smp(); chk("bp_beat4", {o_byte_strobes, o_word_inc, o_last}, {8'h03, 1'b1, 1'b1}); step();
    smp(); chk("bp_end", o_valid, 0);

    // Back-to-back: next request accepted on the previous request's final beat.
    step();
    i_valid = 1'b1; i_byte_enables = 5'b01_010; i_len = 8'd1; o_ready = 1'b1;
    smp(); step();
    i_valid = 1'b0;
    smp(); chk("b2b_beat1", o_byte_strobes, 8'h0C); step();
    i_valid = 1'b1; i_byte_enables = 5'b00_111; i_len = 8'd0;
    smp();
    chk("b2b_last", o_last, 1);
    chk("b2b_i_ready", i_ready, 1);
    step();
    i_valid = 1'b0;
    smp();
    chk("b2b_no_bubble", o_valid, 1);
    chk("b2b_second", {o_byte_strobes, o_addr_offset, o_word_inc, o_last}, {8'h80, 3'd7, 1'b0, 1'b1});
    step();
    smp(); chk("b2b_end", o_valid, 0);

    // Reset in the middle of a 4-beat burst.
    step();
    i_valid = 1'b1; i_byte_enables = 5'b01_010; i_len = 8'd3; o_ready = 1'b1;
    smp(); step();
    i_valid = 1'b0;
    smp(); step();
    smp(); chk("mid_beat2", o_byte_strobes, 8'h30);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_outputs", {o_byte_strobes, o_addr_offset, o_last}, 0);
    chk("mid_rst_i_ready", i_ready, 0);
    step(); smp();
    reset = 1'b0;
    step(); smp();
    chk("post_rst_idle", o_valid, 0);
    chk("post_rst_i_ready", i_ready, 1);
    run_vec(1);

    // Randomized traffic against the beat-list model.
    have = 1'b0;
    repeat (4000) begin
      step();
      if (!have && ($urandom_range(0, 2) != 0)) begin
        have = 1'b1;
        i_byte_enables = 5'($urandom);
        i_len = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 5));
      end
      i_valid = have;
      o_ready = ($urandom_range(0, 3) != 0);
      smp();
      chk("rnd_valid", o_valid, (q.size() != 0));
      exp_ready = (q.size() == 0) || (o_ready && q.size() == 1);
      chk("rnd_i_ready", i_ready, exp_ready);
      if (o_valid && q.size() != 0)
        chk("rnd_beat", {o_byte_strobes, o_addr_offset, o_word_inc, o_last, o_err}, q[0]);
      if (o_valid && o_ready && q.size() != 0) void'(q.pop_front());
      if (i_valid && i_ready) begin
        push_req(i_byte_enables, i_len);
        have = 1'b0;
      end
    end

    step();
    i_valid = 1'b0; o_ready = 1'b1;
    guard = 0;
    while ((q.size() != 0 || o_valid) && guard < 600) begin
      smp();
      if (o_valid && q.size() != 0) begin
        chk("drain_beat", {o_byte_strobes, o_addr_offset, o_word_inc, o_last, o_err}, q[0]);
        void'(q.pop_front());
      end
      step();
      guard++;
    end
    chk("drain_done", (q.size() == 0) && !o_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
